// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   result_t : classification of one full scan frame (NONE / KEY / MULTI)
//   state_t  : key FSM state (IDLE / PRESSED)
//   KEYMAP   : position p = {row, col} -> hex key code
//   ROWS/COLS: matrix dimensions
package keypad_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    typedef enum logic [1:0] {NONE, KEY, MULTI} result_t;
    typedef enum logic {IDLE, PRESSED} state_t;
    // Phone-style layout: * reports E, # reports F.
    localparam logic [0:15][3:0] KEYMAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };
endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix and key-report signals.
//   col       : column readback, active-low (pad -> scanner)
//   row       : row strobe, active-low, one-hot-low (scanner -> pad)
//   key_code  : hex value of the last accepted key
//   key_valid : one-cycle pulse on an accepted press
//   key_held  : accepted key still pressed
interface keypad_if;
    import keypad_pkg::*;
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    logic [3:0] key_code;
    logic key_valid;
    logic key_held;
    modport master (input col, output row, key_code, key_valid, key_held);
    modport slave (output col, input row, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the asynchronous column inputs.
//   clock, reset : system clock, synchronous active-high reset
//   d            : raw columns
//   q            : synchronized columns (resets to all-released)
module keypad_sync
    import keypad_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [COLS-1:0] d,
    output logic [COLS-1:0] q
);
    logic [COLS-1:0] meta;
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad and reports debounced single-key presses.
//   clock, reset : system clock, synchronous active-high reset
//   pad          : keypad_if master (col in; row, key_code, key_valid, key_held out)
//   CLK_DIV      : clocks per scan tick (>= 4)
//   DEBOUNCE     : identical frames needed to accept a press or release (1..15)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV  = 100_000,
    parameter int DEBOUNCE = 4
) (
    input logic      clock,
    input logic      reset,
    keypad_if.master pad
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);
    logic [COLS-1:0] col_s;
    logic [CW-1:0] cnt;
    logic [1:0] ridx;
    logic [1:0] acc_n;
    logic [3:0] acc_p;
    result_t prev_res;
    logic [3:0] prev_p;
    logic [3:0] stable_cnt;
    state_t state;
    logic [3:0] key_code;
    logic key_valid;
    logic tick, eval, settled;
    logic [COLS-1:0] zeros;
    logic [2:0] n_row, sum;
    logic [1:0] c_row, base_n, frame_n;
    logic [3:0] frame_p, res_p, next_cnt;
    result_t res;

    keypad_sync u_sync (.clock(clock), .reset(reset), .d(pad.col), .q(col_s));

    // Frame accumulation: acc_n is a saturating count of pressed positions
    // (0, 1, 2+) and acc_p remembers the position of the first one seen.
    // Row 0 starts a fresh frame; the row-3 tick folds in its own sample and
    // evaluates the whole frame in the same cycle.
    always_comb begin
        tick     = cnt == CW'(CLK_DIV - 1);
        eval     = tick && ridx == 2'd3;
        zeros    = ~col_s;
        n_row    = 3'($countones(zeros));
        c_row    = zeros[0] ? 2'd0 : zeros[1] ? 2'd1 : zeros[2] ? 2'd2 : 2'd3;
        base_n   = ridx == 2'd0 ? 2'd0 : acc_n;
        sum      = {1'b0, base_n} + n_row;
        frame_n  = sum > 3'd1 ? 2'd2 : sum[1:0];
        frame_p  = (base_n == 2'd0 && n_row == 3'd1) ? {ridx, c_row} : acc_p;
        res      = frame_n == 2'd0 ? NONE : frame_n == 2'd1 ? KEY : MULTI;
        res_p    = res == KEY ? frame_p : 4'd0;
        next_cnt = (res == prev_res && res_p == prev_p) ?
                   (stable_cnt == DEB ? DEB : stable_cnt + 4'd1) : 4'd1;
        settled  = next_cnt == DEB;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            ridx       <= 2'd0;
            acc_n      <= 2'd0;
            acc_p      <= 4'd0;
            prev_res   <= NONE;
            prev_p     <= 4'd0;
            stable_cnt <= 4'd0;
            state      <= IDLE;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            cnt       <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                ridx  <= ridx + 2'd1;
                acc_n <= frame_n;
                acc_p <= frame_p;
            end
            if (eval) begin
                prev_res   <= res;
                prev_p     <= res_p;
                stable_cnt <= next_cnt;
                // No rollover: while PRESSED only a settled release leaves.
                if (state == IDLE && res == KEY && settled) begin
                    state     <= PRESSED;
                    key_code  <= KEYMAP[res_p];
                    key_valid <= 1'b1;
                end else if (state == PRESSED && res == NONE && settled) begin
                    state <= IDLE;
                end
            end
        end
    end

    assign pad.row       = ~(4'b0001 << ridx);
    assign pad.key_code  = key_code;
    assign pad.key_valid = key_valid;
    assign pad.key_held  = state == PRESSED;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed vector table, hand-written corner sequences and
// random key activity, all checked every cycle against a frame-level model.
module tb_keypad_scanner;
    localparam int CLK_DIV = 4;
    localparam int DEB = 2;
    localparam int FRAME = 4 * CLK_DIV;
    localparam logic [3:0] HEX [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                        4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [15:0] pressed = 16'h0;
    logic [3:0] pad_col;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    keypad_if pad ();
    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEB)) dut (
        .clock(clock), .reset(reset), .pad(pad));

    always #5 clock = ~clock;

    // Physical pad: a pressed key shorts its column to its row strobe.
    always_comb begin
        pad_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !pad.row[r]) pad_col[c] = 1'b0;
    end
    assign pad.col = pad_col;

    // Reference model: time t since reset gives the scanned row; the reading
    // used at a tick is the pad seen two clocks earlier. Each frame's 16-bit
    // pressed mask is classified by popcount and debounced.
    int t = 0;
    logic [3:0] h1 = 4'hF, h2 = 4'hF;
    logic [15:0] seen = 16'h0;
    int prev_res = 0, prev_p = 0, scnt = 0;
    bit m_held = 0, m_valid = 0;
    logic [3:0] m_code = 4'h0, m_row = 4'b1110;

    always @(posedge clock) begin
        int ri, n, p, res, nc;
        logic [3:0] cnow;
        logic [15:0] sn;
        bit nh, nv;
        logic [3:0] ncode;
        if (reset) begin
            t <= 0; h1 <= 4'hF; h2 <= 4'hF;
            prev_res <= 0; prev_p <= 0; scnt <= 0;
            m_held <= 0; m_valid <= 0; m_code <= 4'h0; m_row <= 4'b1110;
        end else begin
            ri = (t / CLK_DIV) % 4;
            cnow = 4'hF;
            for (int c = 0; c < 4; c++) if (pressed[ri*4+c]) cnow[c] = 1'b0;
            sn = seen; nv = 0; nh = m_held; ncode = m_code;
            if (t % CLK_DIV == CLK_DIV - 1) begin
                for (int c = 0; c < 4; c++) sn[ri*4+c] = ~h2[c];
                if (ri == 3) begin
                    n = $countones(sn);
                    res = n == 0 ? 0 : n == 1 ? 1 : 2;
                    p = 0;
                    if (n == 1) for (int i = 0; i < 16; i++) if (sn[i]) p = i;
                    nc = (res == prev_res && p == prev_p) ? (scnt < DEB ? scnt + 1 : DEB) : 1;
                    if (!m_held && res == 1 && nc == DEB) begin
                        nh = 1; nv = 1; ncode = HEX[p];
                    end else if (m_held && res == 0 && nc == DEB) nh = 0;
                    prev_res <= res; prev_p <= p; scnt <= nc;
                end
            end
            seen <= sn; h1 <= cnow; h2 <= h1; t <= t + 1;
            m_held <= nh; m_valid <= nv; m_code <= ncode;
            m_row <= ~(4'b0001 << (((t + 1) / CLK_DIV) % 4));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("row", 32'(pad.row), 32'(m_row));
            check("key_valid", 32'(pad.key_valid), 32'(m_valid));
            check("key_code", 32'(pad.key_code), 32'(m_code));
            check("key_held", 32'(pad.key_held), 32'(m_held));
        end
    end

    task automatic run(input int cycles, inout int pulses, inout logic [3:0] last);
        repeat (cycles) begin
            @(negedge clock);
            if (pad.key_valid) begin
                pulses++;
                last = pad.key_code;
            end
        end
    endtask

    typedef struct packed {
        logic [15:0] keys;
        logic [7:0]  frames;
        logic [3:0]  pulses;
        logic [3:0]  code;
        logic        held;
    } vec_t;
    vec_t vecs [12];

    initial begin
        int pulses;
        logic [3:0] last;
        vecs = '{
            '{16'h0000, 8'd4, 4'd0, 4'h0, 1'b0},
            '{16'h0040, 8'd5, 4'd1, 4'h6, 1'b1},
            '{16'h0000, 8'd5, 4'd0, 4'h6, 1'b0},
            '{16'h2000, 8'd5, 4'd1, 4'h0, 1'b1},
            '{16'h2001, 8'd5, 4'd0, 4'h0, 1'b1},
            '{16'h0000, 8'd5, 4'd0, 4'h0, 1'b0},
            '{16'h0001, 8'd5, 4'd1, 4'h1, 1'b1},
            '{16'h0000, 8'd5, 4'd0, 4'h1, 1'b0},
            '{16'h0002, 8'd5, 4'd1, 4'h2, 1'b1},
            '{16'h0000, 8'd5, 4'd0, 4'h2, 1'b0},
            '{16'h0004, 8'd5, 4'd1, 4'h3, 1'b1},
            '{16'h0000, 8'd5, 4'd0, 4'h3, 1'b0}
        };
        last = 4'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_row", 32'(pad.row), 32'h e);
        check("reset_code", 32'(pad.key_code), 32'h0);
        check("reset_valid", 32'(pad.key_valid), 32'h0);
        check("reset_held", 32'(pad.key_held), 32'h0);

        for (int i = 0; i < 12; i++) begin
            pressed = vecs[i].keys;
            pulses = 0;
            run(int'(vecs[i].frames) * FRAME, pulses, last);
            check("vec_pulses", 32'(pulses), 32'(vecs[i].pulses));
            check("vec_code", 32'(pad.key_code), 32'(vecs[i].code));
            check("vec_held", 32'(pad.key_held), 32'(vecs[i].held));
        end

        // Key (2,3) bouncing one frame on, one frame off never settles.
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            pressed = 16'h0800;
            run(FRAME, pulses, last);
            pressed = 16'h0000;
            run(FRAME, pulses, last);
        end
        check("bounce_pulses", 32'(pulses), 32'd0);
        check("bounce_held", 32'(pad.key_held), 32'd0);
        pressed = 16'h0800;
        run(5 * FRAME, pulses, last);
        check("bounce_hold_pulses", 32'(pulses), 32'd1);
        check("bounce_hold_code", 32'(pad.key_code), 32'hC);
        pressed = 16'h0000;
        run(5 * FRAME, pulses, last);

        // Reset while (3,3) is held, then release and press again.
        pulses = 0;
        pressed = 16'h8000;
        run(5 * FRAME, pulses, last);
        check("d_pulses", 32'(pulses), 32'd1);
        check("d_code", 32'(last), 32'hD);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pressed = 16'h0000;
        check("rst_row", 32'(pad.row), 32'he);
        check("rst_code", 32'(pad.key_code), 32'h0);
        check("rst_valid", 32'(pad.key_valid), 32'h0);
        check("rst_held", 32'(pad.key_held), 32'h0);
        pulses = 0;
        run(5 * FRAME, pulses, last);
        check("rst_idle_pulses", 32'(pulses), 32'd0);
        pressed = 16'h8000;
        run(5 * FRAME, pulses, last);
        check("repress_pulses", 32'(pulses), 32'd1);
        check("repress_code", 32'(pad.key_code), 32'hD);
        check("repress_held", 32'(pad.key_held), 32'd1);
        pressed = 16'h0000;
        run(5 * FRAME, pulses, last);
        check("release_held", 32'(pad.key_held), 32'd0);

        // Random key activity with occasional resets; the model checks each cycle.
        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [15:0] m;
            kind = int'($urandom_range(0, 3));
            m = 16'h0;
            if (kind != 0) m[$urandom_range(0, 15)] = 1'b1;
            if (kind == 3) m[$urandom_range(0, 15)] = 1'b1;
            pressed = m;
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            run(int'($urandom_range(1, 80)), pulses, last);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
